// File: rtl/alu_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - state_e    : FSM state encoding
//   - OpMul/OpDiv: encodings of the C_MulDivOp input
//   - WidthDefault: default operand width
package alu_muldiv_iter_pkg;

  localparam int unsigned WidthDefault = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic OpMul = 1'b0;
  localparam logic OpDiv = 1'b1;

endpackage

// File: rtl/alu_muldiv_iter_cond_negate.sv
// Conditional two's-complement negate, used for operand magnitude extraction and
// for applying the result sign after the unsigned iteration.
//   data_i : value in
//   neg_i  : 1 = output is -data_i, 0 = pass through
//   data_o : result
module cond_negate #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] data_i,
  input  logic             neg_i,
  output logic [Width-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + 1'b1) : data_i;

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, WIDTH iterations per operation.
//   clk, reset      : clock, asynchronous active-high reset
//   ALU_1_IN/2_IN   : operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   C_MulDivStart   : start request, accepted in IDLE or DONE only
//   C_MulDivOp      : 0 multiply, 1 divide
//   C_MulDivSigned  : 1 two's-complement operands
//   D_Hi / D_Lo     : MUL product high/low; DIV remainder/quotient
//   C_MulDivBusy    : high in CALC and FIX
//   C_MulDivDone    : one-cycle pulse in DONE
//   C_DivZero       : divide by zero seen, held until the next accepted start
module alu_muldiv_iter
  import alu_muldiv_iter_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALU_1_IN,
  input  logic [WIDTH-1:0] ALU_2_IN,
  input  logic             C_MulDivStart,
  input  logic             C_MulDivOp,
  input  logic             C_MulDivSigned,
  output logic [WIDTH-1:0] D_Hi,
  output logic [WIDTH-1:0] D_Lo,
  output logic             C_MulDivBusy,
  output logic             C_MulDivDone,
  output logic             C_DivZero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic                 res_sign_q, res_sign_d;  // product / quotient sign
  logic                 rem_sign_q, rem_sign_d;  // remainder takes the dividend sign
  logic [WIDTH-1:0]     opd_q, opd_d;            // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;            // MUL {hi,multiplier}; DIV {rem,quo}
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH-1:0]     a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix;

  cond_negate #(.Width(WIDTH)) u_neg_a (
    .data_i(ALU_1_IN), .neg_i(C_MulDivSigned & ALU_1_IN[WIDTH-1]), .data_o(a_mag)
  );
  cond_negate #(.Width(WIDTH)) u_neg_b (
    .data_i(ALU_2_IN), .neg_i(C_MulDivSigned & ALU_2_IN[WIDTH-1]), .data_o(b_mag)
  );
  cond_negate #(.Width(2*WIDTH)) u_neg_prod (
    .data_i(acc_q), .neg_i(res_sign_q), .data_o(prod_fix)
  );
  cond_negate #(.Width(WIDTH)) u_neg_quo (
    .data_i(acc_q[WIDTH-1:0]), .neg_i(res_sign_q), .data_o(quo_fix)
  );
  cond_negate #(.Width(WIDTH)) u_neg_rem (
    .data_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rem_sign_q), .data_o(rem_fix)
  );

  // One shift-add multiply step: conditional add into the upper half, then shift right
  // with the carry entering from the top.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring-divide step. The shifted remainder needs WIDTH+1 bits since it can
  // reach 2*divisor-1.
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic [2*WIDTH-1:0] div_next;
  always_comb begin
    div_sh  = {acc_q, 1'b0};
    rem_sh  = div_sh[2*WIDTH:WIDTH];
    rem_sub = rem_sh - {1'b0, opd_q};
    if (rem_sh >= {1'b0, opd_q}) begin
      div_next = {rem_sub[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], div_sh[WIDTH-1:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    res_sign_d = res_sign_q;
    rem_sign_d = rem_sign_q;
    opd_d      = opd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dz_d       = dz_q;
    case (state_q)
      StIdle, StDone: begin
        if (C_MulDivStart) begin
          op_d       = C_MulDivOp;
          res_sign_d = C_MulDivSigned & (ALU_1_IN[WIDTH-1] ^ ALU_2_IN[WIDTH-1]);
          rem_sign_d = C_MulDivSigned & ALU_1_IN[WIDTH-1];
          opd_d      = (C_MulDivOp == OpMul) ? a_mag : b_mag;
          acc_d      = {{WIDTH{1'b0}}, ((C_MulDivOp == OpMul) ? b_mag : a_mag)};
          cnt_d      = '0;
          dz_d       = 1'b0;
          if (C_MulDivOp == OpDiv && ALU_2_IN == '0) begin
            hi_d    = ALU_1_IN;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        acc_d = (op_q == OpDiv) ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        if (op_q == OpMul) begin
          {hi_d, lo_d} = prod_fix;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StCalc) || (state_d == StFix);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= 1'b0;
      res_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      opd_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      res_sign_q <= res_sign_d;
      rem_sign_q <= rem_sign_d;
      opd_q      <= opd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  assign D_Hi         = hi_q;
  assign D_Lo         = lo_q;
  assign C_MulDivBusy = busy_q;
  assign C_MulDivDone = done_q;
  assign C_DivZero    = dz_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Bench for alu_muldiv_iter: a latency-countdown reference model updated on each clock
// edge, compared against every DUT output on every falling edge, plus directed cases
// with hand-computed results and random operations.
module tb_alu_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ALU_1_IN = '0, ALU_2_IN = '0;
  logic        C_MulDivStart = 1'b0, C_MulDivOp = 1'b0, C_MulDivSigned = 1'b0;
  logic [15:0] D_Hi, D_Lo;
  logic        C_MulDivBusy, C_MulDivDone, C_DivZero;

  int n_checks = 0;
  int n_fail = 0;

  alu_muldiv_iter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .ALU_1_IN(ALU_1_IN), .ALU_2_IN(ALU_2_IN),
    .C_MulDivStart(C_MulDivStart), .C_MulDivOp(C_MulDivOp), .C_MulDivSigned(C_MulDivSigned),
    .D_Hi(D_Hi), .D_Lo(D_Lo), .C_MulDivBusy(C_MulDivBusy), .C_MulDivDone(C_MulDivDone),
    .C_DivZero(C_DivZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: returns {hi, lo}.
  function automatic logic [31:0] ref_result(input logic op, input logic sgn,
                                             input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p, q, r;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (!op) begin
      p = sa * sb;
      return p[31:0];
    end
    if (b == 16'h0) return {a, 16'hFFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[15:0], q[15:0]};
  endfunction

  // Reference model: an accepted operation completes 17 edges later (1 edge for /0).
  logic [15:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_pend = '0;
  int          m_cnt = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (C_MulDivStart) begin
        m_dz = 1'b0;
        if (C_MulDivOp && ALU_2_IN == 16'h0) begin
          m_hi = ALU_1_IN; m_lo = 16'hFFFF; m_dz = 1'b1; m_done = 1'b1;
        end else begin
          m_pend = ref_result(C_MulDivOp, C_MulDivSigned, ALU_1_IN, ALU_2_IN);
          m_cnt  = 17;
        end
      end
      m_busy = (m_cnt > 0);
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("cyc_hi", {16'h0, D_Hi}, {16'h0, m_hi});
      check("cyc_lo", {16'h0, D_Lo}, {16'h0, m_lo});
      check("cyc_busy", {31'h0, C_MulDivBusy}, {31'h0, m_busy});
      check("cyc_done", {31'h0, C_MulDivDone}, {31'h0, m_done});
      check("cyc_dz", {31'h0, C_DivZero}, {31'h0, m_dz});
    end
  end

  // Launch one operation; scramble inputs once it has been accepted.
  task automatic run_op(input logic op, input logic sgn, input logic [15:0] a,
                        input logic [15:0] b, output logic [31:0] res, output logic dz,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    ALU_1_IN = a; ALU_2_IN = b; C_MulDivOp = op; C_MulDivSigned = sgn; C_MulDivStart = 1'b1;
    busy_cnt = 0;
    @(negedge clk);
    C_MulDivStart = 1'b0;
    ALU_1_IN = 16'($urandom); ALU_2_IN = 16'($urandom);
    C_MulDivOp = 1'($urandom); C_MulDivSigned = 1'($urandom);
    lat = 1;
    while (!C_MulDivDone && lat < 40) begin
      if (C_MulDivBusy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    res = {D_Hi, D_Lo};
    dz  = C_DivZero;
  endtask

  task automatic run_check(input string name, input logic op, input logic sgn,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
    logic [31:0] res;
    logic        dz;
    int          lat, bc;
    run_op(op, sgn, a, b, res, dz, lat, bc);
    check({name, "_res"}, res, exp);
    check({name, "_lat"}, lat, 18);
    check({name, "_busy"}, bc, 17);
    check({name, "_dz"}, {31'h0, dz}, 32'h0);
  endtask

  initial begin
    logic [31:0] res;
    logic        dz;
    int          lat, bc, t;
    logic [15:0] corner [4];
    corner[0] = 16'h0000; corner[1] = 16'h8000; corner[2] = 16'hFFFF; corner[3] = 16'h0001;

    #1;
    check("rst_hi", {16'h0, D_Hi}, 32'h0);
    check("rst_lo", {16'h0, D_Lo}, 32'h0);
    check("rst_flags", {29'h0, C_MulDivBusy, C_MulDivDone, C_DivZero}, 32'h0);

    // Pin the model against hand-computed values.
    check("ref_umul", ref_result(1'b0, 1'b0, 16'hFFFF, 16'hFFFF), 32'hFFFE_0001);
    check("ref_smul", ref_result(1'b0, 1'b1, 16'hFFFD, 16'h0005), 32'hFFFF_FFF1);
    check("ref_sdiv", ref_result(1'b1, 1'b1, 16'hFFF9, 16'h0002), 32'hFFFF_FFFD);
    check("ref_ovf", ref_result(1'b1, 1'b1, 16'h8000, 16'hFFFF), 32'h0000_8000);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_check("umul_ffff", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_check("smul_m3x5", 1'b0, 1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1);
    run_check("umul_m3x5", 1'b0, 1'b0, 16'hFFFD, 16'h0005, 32'h0004_FFF1);
    run_check("sdiv_m7_2", 1'b1, 1'b1, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD);
    run_check("udiv_100_7", 1'b1, 1'b0, 16'd100, 16'd7, {16'd2, 16'd14});
    run_check("sdiv_ovf", 1'b1, 1'b1, 16'h8000, 16'hFFFF, 32'h0000_8000);

    // Divide by zero completes on the accepting edge.
    run_op(1'b1, 1'b0, 16'h1234, 16'h0000, res, dz, lat, bc);
    check("dz_res", res, 32'h1234_FFFF);
    check("dz_flag", {31'h0, dz}, 32'h1);
    check("dz_lat", lat, 1);
    check("dz_busy", bc, 0);
    run_check("dz_clear", 1'b0, 1'b0, 16'd9, 16'd9, 32'd81);

    // Start held high: ignored in flight, accepted again in DONE.
    @(negedge clk);
    ALU_1_IN = 16'h1234; ALU_2_IN = 16'h0056;
    C_MulDivOp = 1'b0; C_MulDivSigned = 1'b0; C_MulDivStart = 1'b1;
    repeat (5) @(negedge clk);
    ALU_1_IN = 16'hAAAA; ALU_2_IN = 16'h5555;
    t = 5;
    while (!C_MulDivDone && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("hold_res", {D_Hi, D_Lo}, 32'h0006_1D78);
    check("hold_lat", t, 18);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!C_MulDivDone && t < 40);
    C_MulDivStart = 1'b0;
    check("b2b_gap", t, 18);
    check("b2b_res", {D_Hi, D_Lo}, ref_result(1'b0, 1'b0, 16'hAAAA, 16'h5555));

    // Random operations with a bias toward corner operands.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a, b;
      logic        op, sgn;
      a   = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 16'($urandom);
      b   = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 16'($urandom);
      op  = 1'($urandom);
      sgn = 1'($urandom);
      run_op(op, sgn, a, b, res, dz, lat, bc);
      check("rnd_res", res, ref_result(op, sgn, a, b));
      check("rnd_lat", lat, (op && b == 16'h0) ? 1 : 18);
    end

    // Asynchronous reset between E8 and E9 of a multiply.
    run_check("pre_rst", 1'b0, 1'b0, 16'h0123, 16'h0456, ref_result(1'b0, 1'b0, 16'h0123,
                                                                     16'h0456));
    @(negedge clk);
    ALU_1_IN = 16'h1234; ALU_2_IN = 16'h5678; C_MulDivOp = 1'b0; C_MulDivStart = 1'b1;
    @(negedge clk);
    C_MulDivStart = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_out", {D_Hi, D_Lo}, 32'h0);
    check("arst_flags", {29'h0, C_MulDivBusy, C_MulDivDone, C_DivZero}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_check("post_rst", 1'b0, 1'b0, 16'd3, 16'd4, 32'd12);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_muldiv_iter.md
Name: alu_muldiv_iter

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the pre-ALU operand muxes.
- Consumes ALU_1_IN and ALU_2_IN alongside the combinational ALU and handles MUL/DIV opcodes.
- Produces a 32-bit result split across D_Hi and D_Lo, with a start/busy/done handshake so control can stall the pipeline while it runs.

Parameters:
- WIDTH, 16, operand width. Result width is 2*WIDTH. Iteration count is WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ALU_1_IN  in  16  operand A (multiplicand or dividend)
- ALU_2_IN  in  16  operand B (multiplier or divisor)
- C_MulDivStart  in  1  start request; sampled only in IDLE or DONE
- C_MulDivOp  in  1  0 = multiply, 1 = divide
- C_MulDivSigned  in  1  1 = two's-complement operands, 0 = unsigned
- D_Hi  out  16  MUL: product[31:16]; DIV: remainder
- D_Lo  out  16  MUL: product[15:0]; DIV: quotient
- C_MulDivBusy  out  1  high in CALC and FIX
- C_MulDivDone  out  1  one-cycle pulse in DONE; results valid
- C_DivZero  out  1  set when a divide by zero completes; held until next accepted start

Behaviour:
- Reset (async, any state): state = IDLE; D_Hi, D_Lo, counter and internal registers = 0; Busy, Done, DivZero = 0.
- States: IDLE, CALC, FIX, DONE.
- Edge E0, start accepted (Start=1 in IDLE or DONE):
  - Latch op and signed flags.
  - Latch the magnitudes of both operands. Take the absolute value only when Signed=1; 0x8000 has magnitude 0x8000 as unsigned.
  - Latch the result sign: MUL uses A^B; DIV quotient uses A^B; DIV remainder uses the sign of A.
  - Clear DivZero. Counter = 0. State goes to CALC.
- Divide-by-zero exception at E0 (Op=1 and ALU_2_IN=0): go directly to DONE instead of CALC, with D_Lo=16'hFFFF, D_Hi=ALU_1_IN and DivZero=1. Done is therefore high after E0 in this case.
- CALC, one iteration per edge, E1 to E16:
  - MUL: shift-add. Add the multiplicand into the upper half of a 32-bit accumulator when multiplier bit[0]=1, then shift right 1.
  - DIV: restoring division. Shift {rem,quo} left 1; trial-subtract the divisor from rem; on no borrow, keep the result and set quo[0]=1.
  - At E16 (counter = WIDTH-1), state goes to FIX.
- FIX at E17: negate the product, quotient or remainder per the latched signs; register D_Hi/D_Lo; state goes to DONE.
- DONE: Done=1 for exactly this cycle. Outputs hold until the next accepted start completes its FIX or DZ load. With no start pending, state returns to IDLE at the next edge.
- Latency: start sampled at E0, Done high in the cycle after E17 (17 edges). Back-to-back: a start sampled during DONE is accepted, so throughput is 1 operation per 18 cycles.
- Start during CALC or FIX is ignored. Operands and flags must not change the in-flight result.
- Signed overflow -32768 / -1: quotient 16'h8000, remainder 0, DivZero=0.
- Busy and Done are never high together.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3)
  - C_MulDivOp encodings (OP_MUL=1'b0, OP_DIV=1'b1)
  - WIDTH default
- The sign/magnitude conversion (conditional two's-complement negate) is a natural small combinational sub-module, cond_negate, instantiated for operand entry and result fix-up.
- The FSM and iteration datapath stay in alu_muldiv_iter.

Test Plan:
- Unsigned MUL 16'hFFFF × 16'hFFFF, Signed=0 -> after 17 edges: Hi=16'hFFFE, Lo=16'h0001, Done pulse of 1 cycle, Busy high for 17 cycles.
- Signed MUL -3 (16'hFFFD) × 5 -> Hi=16'hFFFF, Lo=16'hFFF1. Signed=0 with the same operands -> 32'h0004_FFF1 (65533 × 5 = 327665).
- Signed DIV -7 / 2 -> Lo=16'hFFFD (-3), Hi=16'hFFFF (-1). Unsigned DIV 100 / 7 -> Lo=14, Hi=2. Signed DIV 16'h8000 / 16'hFFFF -> Lo=16'h8000, Hi=0.
- DIV 16'h1234 / 0 -> after E0: Done=1, Lo=16'hFFFF, Hi=16'h1234, DivZero=1, Busy never high. Next accepted start clears DivZero.
- Start held high through CALC, with operands changed at E5 -> the original result is unchanged. A start held during DONE launches a second operation and its Done arrives 18 cycles after the first.
- Reset asserted asynchronously mid-CALC (between E8 and E9) -> outputs go to 0 immediately and state is IDLE. After deassertion, a new MUL 3×4 returns Lo=12, Hi=0.
